fetch_pipe: RTL

Parametrised front end of the axis_cpu controller: issues instruction-memory reads and advances the PC, then carries each fetched instruction through a configurable number of idle register stages to the decode stage. It generalises the single optional idle stage to 0..IDLE_STAGES slices. Each in-flight entry carries a saturating age count (PC_en pulses since its fetch) for downstream jump correction, and the block reports its occupancy. It sits between code memory and stage1, and is flushed by stage2's branch_mispredict.

---
 rtl/fetch_pipe_pkg.sv | 25 ++
 rtl/fetch_pipe_idle_stage.sv | 73 +++++++
 rtl/fetch_pipe.sv | 117 +++++++++++
 3 files changed

// File: rtl/fetch_pipe_pkg.sv
`default_nettype none
// ============================================================================
// Module      : fetch_pipe_pkg
// Description : Shared constants and helpers for the fetch front end
//               (idle-stage limit, saturating age increment).
// Revision    : 1.0 - initial release
// ============================================================================
package fetch_pipe_pkg;

  // Upper bound on the number of idle register slices behind the F stage.
  localparam int FETCH_MAX_IDLE = 4;

  // Saturating +0/+1 on an age count carried in the low bits of a 32-bit word.
  // The caller passes the saturation ceiling for its own count width.
  function automatic logic [31:0] fetch_sat_inc(input logic [31:0] v,
                                                input logic        inc,
                                                input logic [31:0] maxv);
    logic [31:0] r;
    if (v >= maxv) r = maxv;
    else           r = v + {31'd0, inc};
    return r;
  endfunction

endpackage
`default_nettype wire

// File: rtl/fetch_pipe_idle_stage.sv
`default_nettype none
// ============================================================================
// Module      : fetch_pipe_idle_stage
// Description : One idle register slice of the fetch pipe: valid flag,
//               instruction and saturating age count, with flush.
// Revision    : 1.0 - initial release
// ============================================================================
module fetch_pipe_idle_stage
  import fetch_pipe_pkg::*;
#(
  parameter int INSTR_WIDTH = 8,
  parameter int COUNT_WIDTH = 6
) (
  input  logic                   clk,
  input  logic                   rst,          // asynchronous, active-low
  input  logic                   flush_i,      // branch_mispredict
  input  logic                   rdy_i,        // this slice may take a new entry
  input  logic                   pc_en_i,      // PC increment of this cycle
  input  logic                   up_vld_i,
  input  logic [INSTR_WIDTH-1:0] up_instr_i,
  input  logic [COUNT_WIDTH-1:0] up_cnt_i,
  output logic                   vld_o,
  output logic [INSTR_WIDTH-1:0] instr_o,
  output logic [COUNT_WIDTH-1:0] cnt_o
);

  localparam logic [31:0] CNT_MAX = 32'((64'd1 << COUNT_WIDTH) - 64'd1);

  logic                   vld_q,   vld_d;
  logic [INSTR_WIDTH-1:0] instr_q, instr_d;
  logic [COUNT_WIDTH-1:0] cnt_q,   cnt_d;

  // Next state: flush clears, otherwise load from upstream when ready, else hold.
  // Both a move and a hold add this cycle's PC_en to the entry's age.
  always_comb begin
    vld_d   = vld_q;
    instr_d = instr_q;
    cnt_d   = cnt_q;
    if (flush_i) begin
      vld_d = 1'b0;
      cnt_d = '0;
    end else if (rdy_i) begin
      vld_d = up_vld_i;
      if (up_vld_i) begin
        instr_d = up_instr_i;
        cnt_d   = COUNT_WIDTH'(fetch_sat_inc(32'(up_cnt_i), pc_en_i, CNT_MAX));
      end else begin
        cnt_d   = '0;
      end
    end else begin
      cnt_d = COUNT_WIDTH'(fetch_sat_inc(32'(cnt_q), pc_en_i, CNT_MAX));
    end
  end

  // Slice registers with asynchronous active-low clear.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      vld_q   <= 1'b0;
      instr_q <= '0;
      cnt_q   <= '0;
    end else begin
      vld_q   <= vld_d;
      instr_q <= instr_d;
      cnt_q   <= cnt_d;
    end
  end

  assign vld_o   = vld_q;
  assign instr_o = instr_q;
  assign cnt_o   = cnt_q;

endmodule
`default_nettype wire

// File: rtl/fetch_pipe.sv
`default_nettype none
// ============================================================================
// Module      : fetch_pipe
// Description : Instruction fetch front end. Issues code-memory reads, carries
//               each fetched word through 0..FETCH_MAX_IDLE idle slices to
//               decode with a saturating age count, reports occupancy and
//               flushes on branch_mispredict.
// Revision    : 1.0 - initial release
// ============================================================================
module fetch_pipe
  import fetch_pipe_pkg::*;
#(
  parameter int IDLE_STAGES = 1,
  parameter int INSTR_WIDTH = 8,
  parameter int COUNT_WIDTH = 6,
  parameter int OCC_WIDTH   = 3
) (
  input  logic                   clk,
  input  logic                   rst,                // asynchronous, active-low
  input  logic                   branch_mispredict,
  input  logic [INSTR_WIDTH-1:0] instr_in,
  output logic                   inst_rd_en,
  output logic                   PC_en,
  output logic [INSTR_WIDTH-1:0] instr_out,
  output logic [COUNT_WIDTH-1:0] ocount,
  output logic                   vld,
  input  logic                   next_rdy,
  output logic [OCC_WIDTH-1:0]   occupancy
);

  // Number of idle slices actually built; out-of-range requests are capped.
  localparam int N = (IDLE_STAGES > FETCH_MAX_IDLE) ? FETCH_MAX_IDLE : IDLE_STAGES;

  // Index 0 is the F stage (data is the memory output itself, age 0);
  // index k = 1..N is idle slice Sk. Outputs are taken from index N.
  logic [N:0]             v_vec;
  logic [N+1:0]           rdy_vec;
  logic [INSTR_WIDTH-1:0] ch_instr [0:N];
  logic [COUNT_WIDTH-1:0] ch_cnt   [0:N];

  logic                   f_vld_q, f_vld_d;
  logic                   fetch;
  logic [OCC_WIDTH-1:0]   occ_sum;

  assign v_vec[0]    = f_vld_q;
  assign ch_instr[0] = instr_in;
  assign ch_cnt[0]   = '0;

  // Ready chain from decode back to F: a slice can accept when it is empty
  // or its successor can accept, so bubbles collapse within the cycle.
  always_comb begin
    rdy_vec        = '0;
    rdy_vec[N + 1] = next_rdy;
    for (int k = N; k >= 0; k--) begin
      rdy_vec[k] = !v_vec[k] || rdy_vec[k + 1];
    end
  end

  // Fetch only out of reset, when not flushing and when F can accept.
  assign fetch      = rst && !branch_mispredict && rdy_vec[0];
  assign inst_rd_en = fetch;
  assign PC_en      = fetch;

  // F valid next state: flush clears; otherwise it tracks the read issued
  // whenever F is ready, and holds while stalled.
  always_comb begin
    f_vld_d = f_vld_q;
    if (branch_mispredict) begin
      f_vld_d = 1'b0;
    end else if (rdy_vec[0]) begin
      f_vld_d = fetch;
    end
  end

  // F stage valid register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      f_vld_q <= 1'b0;
    end else begin
      f_vld_q <= f_vld_d;
    end
  end

  for (genvar k = 1; k <= N; k++) begin : g_idle
    fetch_pipe_idle_stage #(
      .INSTR_WIDTH (INSTR_WIDTH),
      .COUNT_WIDTH (COUNT_WIDTH)
    ) u_stage (
      .clk        (clk),
      .rst        (rst),
      .flush_i    (branch_mispredict),
      .rdy_i      (rdy_vec[k]),
      .pc_en_i    (fetch),
      .up_vld_i   (v_vec[k - 1]),
      .up_instr_i (ch_instr[k - 1]),
      .up_cnt_i   (ch_cnt[k - 1]),
      .vld_o      (v_vec[k]),
      .instr_o    (ch_instr[k]),
      .cnt_o      (ch_cnt[k])
    );
  end

  // Occupancy: population count of every registered valid flag.
  always_comb begin
    occ_sum = '0;
    for (int k = 0; k <= N; k++) begin
      occ_sum = occ_sum + OCC_WIDTH'(v_vec[k]);
    end
  end

  assign occupancy = occ_sum;
  assign vld       = v_vec[N];
  assign instr_out = ch_instr[N];
  assign ocount    = ch_cnt[N];

endmodule
`default_nettype wire
